// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-to-parallel word collector.
// The PARITY state is only reachable when SIPO_PARITY_EN is defined.
package sipo_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// MSB-first shift register with bit counter; done flags the cycle the final data bit shifts in.
// sr_word is the next-state view, so it already holds the full word on the done cycle.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             restart,
    input  logic             sin,
    output logic [WIDTH-1:0] sr_word,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shift/count next-state; a restart makes this bit the first of a new word.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        if (shift_en) begin
            if (restart) begin
                sr_d  = {{(WIDTH-1){1'b0}}, sin};
                cnt_d = CNT_W'(1);
            end else begin
                sr_d = {sr_q[WIDTH-2:0], sin};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    done  = 1'b1;
                    cnt_d = CNT_W'(0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= {WIDTH{1'b0}};
            cnt_q <= CNT_W'(0);
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_word = sr_d;

endmodule

// File: rtl/sipo_word_collector.sv
// Serial-to-parallel word collector with valid/ready holding register and sticky overrun.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame.
module sipo_word_collector
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             parity_err
);

    state_e           state_q, state_d;
    logic             shift_en_s, restart_s, done_s, commit_s, ovr_set_s;
    logic [WIDTH-1:0] sr_word_s;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .restart  (restart_s),
        .sin      (sin),
        .sr_word  (sr_word_s),
        .done     (done_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bit_valid && frame_start) state_d = SHIFT;
                else                          state_d = IDLE;
            end
            SHIFT: begin
                if (bit_valid && !frame_start && done_s) begin
`ifdef SIPO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = SHIFT;
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                if (bit_valid && frame_start) state_d = SHIFT;
                else if (bit_valid)           state_d = IDLE;
                else                          state_d = PARITY;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: when the shift core samples sin and whether it starts a new word.
    always_comb begin
        shift_en_s = 1'b0;
        restart_s  = 1'b0;
        case (state_q)
            IDLE: begin
                shift_en_s = bit_valid && frame_start;
                restart_s  = 1'b1;
            end
            SHIFT: begin
                shift_en_s = bit_valid;
                restart_s  = frame_start;
            end
            PARITY: begin
                shift_en_s = bit_valid && frame_start;
                restart_s  = 1'b1;
            end
            default: begin
                shift_en_s = 1'b0;
                restart_s  = 1'b0;
            end
        endcase
    end

`ifdef SIPO_PARITY_EN
    logic perr_q, perr_s;

    // Commit on the parity bit; a mismatch still commits the word.
    always_comb begin
        commit_s = bit_valid && !frame_start && (state_q == PARITY);
        perr_s   = commit_s && ((^sr_word_s) != sin);
    end

    // Parity error pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_s;
        end
    end

    assign parity_err = perr_q;
`else
    assign commit_s   = done_s;
    assign parity_err = 1'b0;
`endif

    // Holding register: a drain and a completion on the same edge keep word_valid high.
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        ovr_set_s = 1'b0;
        if (commit_s) begin
            if (!valid_q || word_ready) begin
                word_d  = sr_word_s;
                valid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (ovr_set_s)        ovr_d = 1'b1;
        else if (overrun_clr) ovr_d = 1'b0;
        else                  ovr_d = ovr_q;
    end

    // Holding register and sticky overrun state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule
